pending_instr_tracker: RTL and testbench



---
 rtl/pending_instr_tracker.sv | 136 +++++++++++++
 tb/tb_pending_instr_tracker.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pending_instr_tracker.sv
// Per-warp in-flight instruction counters with a registered pending mask,
// sticky saturation/underflow flags and a single-outstanding drain handshake.
module pending_instr_tracker #(
   parameter int unsigned NUM_WARPS   = 4,
   parameter int unsigned ISSUE_WIDTH = 2,
   parameter int unsigned CTR_WIDTH   = 6,
   localparam int unsigned NW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [ISSUE_WIDTH-1:0]          issue_fire,
   input  logic [ISSUE_WIDTH-1:0][NW-1:0]  issue_wid,
   input  logic [ISSUE_WIDTH-1:0]          committed,
   input  logic [ISSUE_WIDTH-1:0][NW-1:0]  committed_wid,
   output logic [NUM_WARPS-1:0]            pending,
   input  logic                            drain_valid,
   input  logic [NW-1:0]                   drain_wid,
   output logic                            drain_ready,
   output logic                            done_valid,
   output logic [NW-1:0]                   done_wid,
   output logic                            err_overflow,
   output logic                            err_underflow
);

   localparam int unsigned CW = $clog2(ISSUE_WIDTH + 1);
   localparam int unsigned SW = CTR_WIDTH + 2;
   localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t                                state;
   logic [NW-1:0]                         wid_r;
   logic [NUM_WARPS-1:0][CTR_WIDTH-1:0]   count_q;
   logic [NUM_WARPS-1:0][CTR_WIDTH-1:0]   count_d;
   logic [NUM_WARPS-1:0][CW-1:0]          inc_c;
   logic [NUM_WARPS-1:0][CW-1:0]          dec_c;
   logic signed [SW-1:0]                  sum_c [NUM_WARPS];
   logic [NUM_WARPS-1:0]                  ovf_c;
   logic [NUM_WARPS-1:0]                  unf_c;
   logic                                  wait_zero_c;

   // Per-warp lane population counts of issues and commits.
   always_comb begin
      inc_c = '0;
      dec_c = '0;
      for (int w = 0; w < int'(NUM_WARPS); w++) begin
         for (int l = 0; l < int'(ISSUE_WIDTH); l++) begin
            if (issue_fire[l] && (issue_wid[l] == NW'(w)))
               inc_c[w] = inc_c[w] + CW'(1);
            if (committed[l] && (committed_wid[l] == NW'(w)))
               dec_c[w] = dec_c[w] + CW'(1);
         end
      end
   end

   // Net update with clipping at both ends; same-cycle inc/dec cancel first.
   always_comb begin
      ovf_c = '0;
      unf_c = '0;
      for (int w = 0; w < int'(NUM_WARPS); w++) begin
         sum_c[w]   = $signed({2'b00, count_q[w]}) + $signed(SW'(inc_c[w]))
                      - $signed(SW'(dec_c[w]));
         count_d[w] = sum_c[w][CTR_WIDTH-1:0];
         if (sum_c[w][SW-1]) begin
            count_d[w] = '0;
            unf_c[w]   = 1'b1;
         end else if (sum_c[w] > $signed({2'b00, CTR_MAX})) begin
            count_d[w] = CTR_MAX;
            ovf_c[w]   = 1'b1;
         end
      end
   end

   // Out-of-range drain ids see zero so the handshake cannot hang.
   always_comb begin
      wait_zero_c = 1'b1;
      for (int w = 0; w < int'(NUM_WARPS); w++) begin
         if (wid_r == NW'(w))
            wait_zero_c = (count_q[w] == '0);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q       <= '0;
         pending       <= '0;
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         count_q <= count_d;
         for (int w = 0; w < int'(NUM_WARPS); w++)
            pending[w] <= (count_d[w] != '0);
         if (|ovf_c) err_overflow  <= 1'b1;
         if (|unf_c) err_underflow <= 1'b1;
      end
   end

   // Drain handshake: WAIT checks the registered count, so issues during WAIT delay completion.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         wid_r       <= '0;
         drain_ready <= 1'b1;
         done_valid  <= 1'b0;
         done_wid    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (drain_valid) begin
                  wid_r       <= drain_wid;
                  state       <= WAIT;
                  drain_ready <= 1'b0;
               end
            end
            WAIT: begin
               if (wait_zero_c) begin
                  state      <= DONE;
                  done_valid <= 1'b1;
                  done_wid   <= wid_r;
               end
            end
            DONE: begin
               state       <= IDLE;
               done_valid  <= 1'b0;
               drain_ready <= 1'b1;
            end
            default: begin
               state       <= IDLE;
               done_valid  <= 1'b0;
               drain_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pending_instr_tracker.sv
// Directed vector table for counting/clipping plus hand sequences for the
// drain handshake and asynchronous reset.
module tb_pending_instr_tracker;

   localparam int unsigned NWARP = 4;
   localparam int unsigned IW    = 2;
   localparam int unsigned CTRW  = 3;
   localparam int unsigned NW    = 2;

   logic                    clk;
   logic                    reset;
   logic [IW-1:0]           issue_fire;
   logic [IW-1:0][NW-1:0]   issue_wid;
   logic [IW-1:0]           committed;
   logic [IW-1:0][NW-1:0]   committed_wid;
   logic [NWARP-1:0]        pending;
   logic                    drain_valid;
   logic [NW-1:0]           drain_wid;
   logic                    drain_ready;
   logic                    done_valid;
   logic [NW-1:0]           done_wid;
   logic                    err_overflow;
   logic                    err_underflow;

   int n_cmp;
   int n_err;

   typedef struct {
      logic [1:0] fire;
      logic [1:0] iw0;
      logic [1:0] iw1;
      logic [1:0] cmt;
      logic [1:0] cw0;
      logic [1:0] cw1;
      logic [3:0] pend;
      logic       ovf;
      logic       unf;
   } vec_t;

   vec_t tbl[$];

   pending_instr_tracker #(
      .NUM_WARPS(NWARP), .ISSUE_WIDTH(IW), .CTR_WIDTH(CTRW)
   ) dut (
      .clk(clk), .reset(reset),
      .issue_fire(issue_fire), .issue_wid(issue_wid),
      .committed(committed), .committed_wid(committed_wid),
      .pending(pending),
      .drain_valid(drain_valid), .drain_wid(drain_wid), .drain_ready(drain_ready),
      .done_valid(done_valid), .done_wid(done_wid),
      .err_overflow(err_overflow), .err_underflow(err_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [1:0] fire, input logic [1:0] iw0,
                               input logic [1:0] iw1, input logic [1:0] cmt,
                               input logic [1:0] cw0, input logic [1:0] cw1,
                               input logic [3:0] pend, input logic ovf, input logic unf);
      vec_t v;
      v.fire = fire; v.iw0 = iw0; v.iw1 = iw1;
      v.cmt  = cmt;  v.cw0 = cw0; v.cw1 = cw1;
      v.pend = pend; v.ovf = ovf; v.unf = unf;
      return v;
   endfunction

   task automatic clear_inputs();
      issue_fire    = '0;
      issue_wid     = '0;
      committed     = '0;
      committed_wid = '0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      drain_valid = 1'b0;
      drain_wid   = '0;
      clear_inputs();

      // Reset values
      #12;
      check("rst_pending", 32'(pending), 0);
      check("rst_ready", 32'(drain_ready), 1);
      check("rst_done", 32'(done_valid), 0);
      check("rst_done_wid", 32'(done_wid), 0);
      check("rst_ovf", 32'(err_overflow), 0);
      check("rst_unf", 32'(err_underflow), 0);
      tick();
      reset = 1'b0;

      // Counting on warp 2
      for (int i = 0; i < 3; i++) tbl.push_back(mk(2'b01, 2, 0, 2'b00, 0, 0, 4'b0100, 0, 0));
      tbl.push_back(mk(2'b00, 0, 0, 2'b00, 0, 0, 4'b0100, 0, 0));
      tbl.push_back(mk(2'b00, 0, 0, 2'b01, 2, 0, 4'b0100, 0, 0));
      tbl.push_back(mk(2'b00, 0, 0, 2'b01, 2, 0, 4'b0100, 0, 0));
      tbl.push_back(mk(2'b00, 0, 0, 2'b01, 2, 0, 4'b0000, 0, 0));
      // Cancel at zero: no underflow
      tbl.push_back(mk(2'b01, 2, 0, 2'b10, 0, 2, 4'b0000, 0, 0));
      // Simultaneous events on warp 1
      tbl.push_back(mk(2'b01, 1, 0, 2'b00, 0, 0, 4'b0010, 0, 0));
      tbl.push_back(mk(2'b01, 1, 0, 2'b10, 0, 1, 4'b0010, 0, 0));
      tbl.push_back(mk(2'b00, 0, 0, 2'b11, 1, 1, 4'b0000, 0, 1));
      tbl.push_back(mk(2'b00, 0, 0, 2'b00, 0, 0, 4'b0000, 0, 1));
      // Two lanes issuing to warp 3 sum to 2
      tbl.push_back(mk(2'b11, 3, 3, 2'b00, 0, 0, 4'b1000, 0, 1));
      tbl.push_back(mk(2'b00, 0, 0, 2'b01, 3, 0, 4'b1000, 0, 1));
      tbl.push_back(mk(2'b00, 0, 0, 2'b10, 0, 3, 4'b0000, 0, 1));
      // Saturation on warp 0 (max 7)
      for (int i = 0; i < 7; i++) tbl.push_back(mk(2'b01, 0, 0, 2'b00, 0, 0, 4'b0001, 0, 1));
      tbl.push_back(mk(2'b01, 0, 0, 2'b10, 0, 0, 4'b0001, 0, 1));
      tbl.push_back(mk(2'b01, 0, 0, 2'b00, 0, 0, 4'b0001, 1, 1));
      for (int i = 0; i < 6; i++) tbl.push_back(mk(2'b00, 0, 0, 2'b01, 0, 0, 4'b0001, 1, 1));
      tbl.push_back(mk(2'b00, 0, 0, 2'b01, 0, 0, 4'b0000, 1, 1));

      foreach (tbl[i]) begin
         issue_fire       = tbl[i].fire;
         issue_wid[0]     = tbl[i].iw0;
         issue_wid[1]     = tbl[i].iw1;
         committed        = tbl[i].cmt;
         committed_wid[0] = tbl[i].cw0;
         committed_wid[1] = tbl[i].cw1;
         tick();
         check($sformatf("vec%0d_pending", i), 32'(pending), 32'(tbl[i].pend));
         check($sformatf("vec%0d_ovf", i), 32'(err_overflow), 32'(tbl[i].ovf));
         check($sformatf("vec%0d_unf", i), 32'(err_underflow), 32'(tbl[i].unf));
         check($sformatf("vec%0d_ready", i), 32'(drain_ready), 1);
      end
      clear_inputs();

      // Drain warp 3 at count 0: done two cycles after accept
      drain_valid = 1'b1;
      drain_wid   = 2'd3;
      tick();
      drain_valid = 1'b0;
      check("drainA_ready_wait", 32'(drain_ready), 0);
      check("drainA_done_wait", 32'(done_valid), 0);
      tick();
      check("drainA_done", 32'(done_valid), 1);
      check("drainA_wid", 32'(done_wid), 3);
      check("drainA_ready_done", 32'(drain_ready), 0);
      tick();
      check("drainA_done_clr", 32'(done_valid), 0);
      check("drainA_ready_back", 32'(drain_ready), 1);

      // Drain warp 3 at count 2; second request held from cycle 11
      issue_fire   = 2'b11;
      issue_wid[0] = 2'd3;
      issue_wid[1] = 2'd3;
      tick();
      clear_inputs();
      drain_valid = 1'b1;
      drain_wid   = 2'd3;
      tick();
      drain_wid = 2'd1;
      for (int cyc = 11; cyc <= 25; cyc++) begin
         committed        = (cyc == 20 || cyc == 22) ? 2'b01 : 2'b00;
         committed_wid[0] = 2'd3;
         check($sformatf("drainB_ready_c%0d", cyc), 32'(drain_ready), (cyc <= 24) ? 0 : 1);
         check($sformatf("drainB_done_c%0d", cyc), 32'(done_valid), (cyc == 24) ? 1 : 0);
         if (cyc == 24) check("drainB_wid", 32'(done_wid), 3);
         tick();
      end
      clear_inputs();
      check("drainB2_accepted", 32'(drain_ready), 0);
      drain_valid = 1'b0;
      tick();
      check("drainB2_done", 32'(done_valid), 1);
      check("drainB2_wid", 32'(done_wid), 1);
      tick();
      check("drainB2_done_clr", 32'(done_valid), 0);
      check("drainB2_ready", 32'(drain_ready), 1);

      // Asynchronous reset mid-drain with counts nonzero
      issue_fire   = 2'b01;
      issue_wid[0] = 2'd2;
      tick();
      clear_inputs();
      drain_valid = 1'b1;
      drain_wid   = 2'd2;
      tick();
      drain_valid = 1'b0;
      check("arst_pre_pending", 32'(pending), 32'h4);
      check("arst_pre_ready", 32'(drain_ready), 0);
      #2;
      reset = 1'b1;
      #1;
      check("arst_pending", 32'(pending), 0);
      check("arst_ready", 32'(drain_ready), 1);
      check("arst_done", 32'(done_valid), 0);
      check("arst_done_wid", 32'(done_wid), 0);
      check("arst_ovf", 32'(err_overflow), 0);
      check("arst_unf", 32'(err_underflow), 0);
      tick();
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("arst_post%0d_done", k), 32'(done_valid), 0);
         check($sformatf("arst_post%0d_ready", k), 32'(drain_ready), 1);
         check($sformatf("arst_post%0d_pending", k), 32'(pending), 0);
      end

      // Drain warp 0 while an issue and commit cancel in WAIT
      issue_fire   = 2'b01;
      issue_wid[0] = 2'd0;
      tick();
      clear_inputs();
      drain_valid = 1'b1;
      drain_wid   = 2'd0;
      tick();
      drain_valid      = 1'b0;
      issue_fire       = 2'b01;
      issue_wid[0]     = 2'd0;
      committed        = 2'b10;
      committed_wid[1] = 2'd0;
      check("dwi_done_k1", 32'(done_valid), 0);
      tick();
      clear_inputs();
      for (int k = 2; k <= 7; k++) begin
         committed        = (k == 5) ? 2'b01 : 2'b00;
         committed_wid[0] = 2'd0;
         check($sformatf("dwi_done_k%0d", k), 32'(done_valid), (k == 7) ? 1 : 0);
         check($sformatf("dwi_pending_k%0d", k), 32'(pending), (k <= 5) ? 1 : 0);
         tick();
      end
      clear_inputs();
      check("dwi_ovf", 32'(err_overflow), 0);
      check("dwi_unf", 32'(err_underflow), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
